// File: rtl/deperforator_pkg.sv
// Shared rate encodings, puncture patterns and FSM state type for the deperforator.
package deperforator_pkg;

    typedef enum logic [1:0] {
        RATE_1_2 = 2'd0,
        RATE_2_3 = 2'd1,
        RATE_3_4 = 2'd2,
        RATE_7_8 = 2'd3
    } rate_e;

    typedef enum logic [1:0] {
        WAIT_X = 2'd0,
        WAIT_Y = 2'd1,
        SKIP   = 2'd2
    } state_e;

    // Puncture masks, bit c = column c, 1 = transmitted. Entry order is 7/8, 3/4, 2/3, 1/2.
    localparam logic [3:0][6:0] X_MASK = {7'b1010001, 7'b0000101, 7'b0000001, 7'b0000001};
    localparam logic [3:0][6:0] Y_MASK = {7'b0101111, 7'b0000011, 7'b0000011, 7'b0000001};

    // Symbols per puncture period.
    function automatic logic [3:0] rate_period(rate_e r);
        case (r)
            RATE_1_2: return 4'd2;
            RATE_2_3: return 4'd3;
            RATE_3_4: return 4'd4;
            default:  return 4'd8;
        endcase
    endfunction

    // Columns per puncture period.
    function automatic logic [2:0] rate_cols(rate_e r);
        case (r)
            RATE_1_2: return 3'd1;
            RATE_2_3: return 3'd2;
            RATE_3_4: return 3'd3;
            default:  return 3'd7;
        endcase
    endfunction

    // Column index 7 never exists, so the padded top bit reads as not transmitted.
    function automatic logic col_x_tx(rate_e r, logic [2:0] c);
        logic [7:0] m;
        m = {1'b0, X_MASK[r]};
        return m[c];
    endfunction

    function automatic logic col_y_tx(rate_e r, logic [2:0] c);
        logic [7:0] m;
        m = {1'b0, Y_MASK[r]};
        return m[c];
    endfunction

    // (ph + 1) mod P; correct even if ph came from a longer period before a rate change.
    function automatic logic [2:0] phase_next(rate_e r, logic [2:0] ph);
        logic [3:0] v;
        v = {1'b0, ph} + 4'd1;
        case (r)
            RATE_1_2: return {2'b00, v[0]};
            RATE_2_3: return 3'(v % 4'd3);
            RATE_3_4: return {1'b0, v[1:0]};
            default:  return v[2:0];
        endcase
    endfunction

endpackage

// File: rtl/deperforator_if.sv
// Symbol-in / pair-out bundle between the sync finder path and the deperforator.
interface deperforator_if import deperforator_pkg::*; #(parameter int LLR_WIDTH = 4);
    rate_e                        i_code_rate;
    logic                         i_next_st;
    logic                         i_vld;
    logic signed [LLR_WIDTH-1:0]  i_llr;
    logic                         o_vld;
    logic signed [LLR_WIDTH-1:0]  o_llr_x;
    logic signed [LLR_WIDTH-1:0]  o_llr_y;
    logic                         o_erase_x;
    logic                         o_erase_y;
    logic [2:0]                   o_phase;

    modport master (output i_code_rate, i_next_st, i_vld, i_llr,
                    input  o_vld, o_llr_x, o_llr_y, o_erase_x, o_erase_y, o_phase);
    modport slave  (input  i_code_rate, i_next_st, i_vld, i_llr,
                    output o_vld, o_llr_x, o_llr_y, o_erase_x, o_erase_y, o_phase);
endinterface

// File: rtl/deperf_pattern_rom.sv
// Combinational puncture pattern lookup: (rate, column) -> transmitted flags and wrap marker.
module deperf_pattern_rom import deperforator_pkg::*; (
    input  rate_e      rate,
    input  logic [2:0] col,
    output logic       x_tx,
    output logic       y_tx,
    output logic       last_col
);
    assign x_tx     = col_x_tx(rate, col);
    assign y_tx     = col_y_tx(rate, col);
    assign last_col = (col == rate_cols(rate) - 3'd1);
endmodule

// File: rtl/deperforator.sv
// Depunctures received soft symbols into (X,Y) pairs with zero erasures; kicks slip alignment.
module deperforator import deperforator_pkg::*; #(parameter int LLR_WIDTH = 4) (
    input  logic           clk,
    input  logic           reset_n,
    deperforator_if.slave  bus
);
    state_e                      state, state_d, ent_st;
    logic [2:0]                  col, col_d, ent_col;
    logic signed [LLR_WIDTH-1:0] x_q, x_d;
    rate_e                       rate_q, rate_d, rate_cur, rate_ent;
    logic                        armed;
    logic [2:0]                  phase, phase_d;
    logic                        cur_x, cur_y, cur_last;
    logic                        emit, pex, pey;
    logic signed [LLR_WIDTH-1:0] px, py;
    logic                        ov, oex, oey;
    logic signed [LLR_WIDTH-1:0] ox, oy;

    // Until the first clock after reset the rate follows the input, which latches it at release.
    assign rate_cur = armed ? rate_q : bus.i_code_rate;
    assign rate_ent = bus.i_next_st ? bus.i_code_rate : rate_cur;
    assign ent_col  = (bus.i_next_st || state == SKIP || cur_last) ? 3'd0 : col + 3'd1;
    assign ent_st   = col_x_tx(rate_ent, ent_col) ? WAIT_X : WAIT_Y;

    deperf_pattern_rom u_rom (
        .rate     (rate_cur),
        .col      (col),
        .x_tx     (cur_x),
        .y_tx     (cur_y),
        .last_col (cur_last)
    );

    // Next-state: kick realigns to column 0, otherwise capture X/Y and emit on column completion.
    always_comb begin
        state_d = state;
        col_d   = col;
        x_d     = x_q;
        rate_d  = rate_cur;
        phase_d = phase;
        emit    = 1'b0;
        px      = '0;
        py      = '0;
        pex     = 1'b0;
        pey     = 1'b0;
        if (bus.i_next_st) begin
            rate_d  = bus.i_code_rate;
            phase_d = phase_next(bus.i_code_rate, phase);
            col_d   = 3'd0;
            x_d     = '0;
            state_d = bus.i_vld ? ent_st : SKIP;
        end else if (bus.i_vld) begin
            case (state)
                WAIT_X: begin
                    if (cur_y) begin
                        x_d     = bus.i_llr;
                        state_d = WAIT_Y;
                    end else begin
                        emit    = 1'b1;
                        px      = bus.i_llr;
                        pey     = 1'b1;
                        col_d   = ent_col;
                        state_d = ent_st;
                    end
                end
                WAIT_Y: begin
                    emit    = 1'b1;
                    px      = cur_x ? x_q : '0;
                    pex     = !cur_x;
                    py      = bus.i_llr;
                    col_d   = ent_col;
                    state_d = ent_st;
                end
                SKIP: begin
                    col_d   = 3'd0;
                    state_d = ent_st;
                end
                default: state_d = WAIT_X;
            endcase
        end
    end

    // FSM, column pointer, partial X, latched rate and slip phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= WAIT_X;
            col    <= 3'd0;
            x_q    <= '0;
            rate_q <= RATE_1_2;
            armed  <= 1'b0;
            phase  <= 3'd0;
        end else begin
            state  <= state_d;
            col    <= col_d;
            x_q    <= x_d;
            rate_q <= rate_d;
            armed  <= 1'b1;
            phase  <= phase_d;
        end
    end

    // Output pair register: pulse valid, data holds until the next pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ov  <= 1'b0;
            ox  <= '0;
            oy  <= '0;
            oex <= 1'b0;
            oey <= 1'b0;
        end else begin
            ov <= emit;
            if (emit) begin
                ox  <= px;
                oy  <= py;
                oex <= pex;
                oey <= pey;
            end
        end
    end

    assign bus.o_vld     = ov;
    assign bus.o_llr_x   = ox;
    assign bus.o_llr_y   = oy;
    assign bus.o_erase_x = oex;
    assign bus.o_erase_y = oey;
    assign bus.o_phase   = phase;
endmodule

// File: tb/tb_deperforator.sv
// Self-checking bench: transmission-order role strings model the depuncturing per symbol.
module tb_deperforator;
    import deperforator_pkg::*;

    logic clk;
    logic reset_n;
    deperforator_if #(.LLR_WIDTH(4)) bus ();

    deperforator #(.LLR_WIDTH(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // model state
    int         rate_m, phase_m, k;
    bit         skip_m, hx, hy;
    logic [3:0] mx, my;
    bit         pend_vld, pend_ex, pend_ey;
    logic [3:0] pend_x, pend_y;
    logic       exp_vld, exp_ex, exp_ey;
    logic [3:0] exp_x, exp_y;
    logic [2:0] exp_phase;

    logic [9:0] dut_q[$];
    logic [9:0] lit_q[$];

    // Each transmitted symbol's role in order; '.' closes a column.
    function automatic string rstr(int r);
        case (r)
            0: return "XY.";
            1: return "XY.Y.";
            2: return "XY.Y.X.";
            default: return "XY.Y.Y.Y.X.Y.X.";
        endcase
    endfunction

    function automatic int rper(int r);
        string s;
        int n;
        s = rstr(r);
        n = 0;
        for (int i = 0; i < s.len(); i++) if (s[i] != ".") n++;
        return n;
    endfunction

    task model_reset();
        phase_m = 0; k = 0; skip_m = 0; hx = 0; hy = 0;
        pend_vld = 0;
        exp_vld = 0; exp_x = 0; exp_y = 0; exp_ex = 0; exp_ey = 0; exp_phase = 0;
    endtask

    task model_cycle(input bit kick, input bit vld, input logic [3:0] llr);
        string s;
        byte c;
        pend_vld = 0;
        if (kick) begin
            rate_m  = int'(bus.i_code_rate);
            phase_m = (phase_m + 1) % rper(rate_m);
            k = 0; hx = 0; hy = 0;
            skip_m = !vld;
        end else if (vld) begin
            if (skip_m) begin
                skip_m = 0;
                k = 0;
            end else begin
                s = rstr(rate_m);
                c = s[k];
                if (c == "X") begin mx = llr; hx = 1; end
                else begin my = llr; hy = 1; end
                k++;
                c = s[k];
                if (c == ".") begin
                    pend_vld = 1;
                    pend_x   = hx ? mx : 4'd0;
                    pend_y   = hy ? my : 4'd0;
                    pend_ex  = !hx;
                    pend_ey  = !hy;
                    hx = 0; hy = 0;
                    k++;
                    if (k >= s.len()) k = 0;
                end
            end
        end
    endtask

    task step(input bit kick, input bit vld, input logic [3:0] llr);
        @(negedge clk);
        bus.i_next_st = kick;
        bus.i_vld     = vld;
        bus.i_llr     = llr;
        model_cycle(kick, vld, llr);
        @(posedge clk);
        #1;
        exp_vld = pend_vld;
        if (pend_vld) begin
            exp_x = pend_x; exp_y = pend_y; exp_ex = pend_ex; exp_ey = pend_ey;
        end
        exp_phase = 3'(phase_m);
        bus.i_next_st = 0;
        bus.i_vld     = 0;
    endtask

    task check_val(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task do_reset(input int r);
        @(negedge clk);
        #2;
        reset_n = 0;
        bus.i_code_rate = rate_e'(r);
        bus.i_vld = 0;
        bus.i_next_st = 0;
        model_reset();
        #1;
        check_val("rst_vld",   int'(bus.o_vld), 0);
        check_val("rst_x",     int'(unsigned'(bus.o_llr_x)), 0);
        check_val("rst_y",     int'(unsigned'(bus.o_llr_y)), 0);
        check_val("rst_ex",    int'(bus.o_erase_x), 0);
        check_val("rst_ey",    int'(bus.o_erase_y), 0);
        check_val("rst_phase", int'(bus.o_phase), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        rate_m = r;
    endtask

    task lit(input bit ex, input bit ey, input logic [3:0] x, input logic [3:0] y);
        lit_q.push_back({ex, ey, x, y});
    endtask

    task check_lit(input string name);
        step(0, 0, 0);
        step(0, 0, 0);
        checks++;
        if (dut_q.size() != lit_q.size()) begin
            errors++;
            $display("FAIL %s count: got %0d pairs want %0d", name, dut_q.size(), lit_q.size());
        end else begin
            foreach (lit_q[i]) begin
                checks++;
                if (dut_q[i] !== lit_q[i]) begin
                    errors++;
                    $display("FAIL %s pair%0d: got ex=%b ey=%b x=%h y=%h want ex=%b ey=%b x=%h y=%h",
                             name, i, dut_q[i][9], dut_q[i][8], dut_q[i][7:4], dut_q[i][3:0],
                             lit_q[i][9], lit_q[i][8], lit_q[i][7:4], lit_q[i][3:0]);
                end
            end
        end
        dut_q.delete();
        lit_q.delete();
    endtask

    task syms(input int first, input int last);
        for (int i = first; i <= last; i++) step(0, 1, 4'(i));
    endtask

    // Per-cycle comparison of every output against the model; also logs pairs for literal checks.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (bus.o_vld !== exp_vld || bus.o_llr_x !== exp_x || bus.o_llr_y !== exp_y ||
                bus.o_erase_x !== exp_ex || bus.o_erase_y !== exp_ey || bus.o_phase !== exp_phase) begin
                errors++;
                $display("FAIL cycle t=%0t: got vld=%b x=%h y=%h ex=%b ey=%b ph=%0d want vld=%b x=%h y=%h ex=%b ey=%b ph=%0d",
                         $time, bus.o_vld, bus.o_llr_x, bus.o_llr_y, bus.o_erase_x, bus.o_erase_y, bus.o_phase,
                         exp_vld, exp_x, exp_y, exp_ex, exp_ey, exp_phase);
            end
            if (bus.o_vld === 1'b1)
                dut_q.push_back({bus.o_erase_x, bus.o_erase_y, bus.o_llr_x, bus.o_llr_y});
        end
    end

    initial begin
        clk = 0;
        reset_n = 1;
        bus.i_code_rate = RATE_1_2;
        bus.i_next_st = 0;
        bus.i_vld = 0;
        bus.i_llr = 0;
        rate_m = 0;
        model_reset();

        // rate 1/2 continuous
        do_reset(0);
        chk_en = 1;
        syms(1, 6);
        lit(0,0,1,2); lit(0,0,3,4); lit(0,0,5,6);
        check_lit("r12");

        // rate 3/4
        do_reset(2);
        syms(1, 8);
        lit(0,0,1,2); lit(1,0,0,3); lit(0,1,4,0); lit(0,0,5,6); lit(1,0,0,7); lit(0,1,8,0);
        check_lit("r34");

        // kick alone drops partial pair and discards next symbol
        do_reset(0);
        syms(1, 3);
        step(1, 0, 0);
        syms(4, 6);
        lit(0,0,1,2); lit(0,0,5,6);
        check_lit("kick_alone");
        check_val("kick_alone_phase", int'(bus.o_phase), 1);

        // kick coincident with symbol 4
        do_reset(0);
        syms(1, 3);
        step(1, 1, 4);
        syms(5, 6);
        lit(0,0,1,2); lit(0,0,5,6);
        check_lit("kick_vld");
        check_val("kick_vld_phase", int'(bus.o_phase), 1);

        // rate 7/8 phase sweep, kicks while already skipping
        do_reset(3);
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 0);
            check_val($sformatf("phase78_%0d", i), int'(bus.o_phase), i % 8);
        end
        do_reset(3);
        syms(1, 8);
        lit(0,0,1,2); lit(1,0,0,3); lit(1,0,0,4); lit(1,0,0,5); lit(0,1,6,0); lit(1,0,0,7); lit(0,1,8,0);
        check_lit("r78");

        // gaps, async reset mid-pair, rate change without kick
        do_reset(0);
        step(0, 1, 1); step(0, 0, 0); step(0, 0, 0); step(0, 1, 2);
        step(0, 1, 3);
        do_reset(0);
        step(0, 1, 4);
        bus.i_code_rate = RATE_7_8;
        step(0, 0, 0);
        step(0, 1, 5);
        syms(6, 9);
        lit(0,0,1,2); lit(0,0,4,5); lit(0,0,6,7); lit(0,0,8,9);
        check_lit("gaps_reset");

        // randomized traffic with kicks, rate changes and occasional resets
        for (int it = 0; it < 6; it++) begin
            do_reset(int'($urandom_range(0, 3)));
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 99) < 2)
                    bus.i_code_rate = rate_e'($urandom_range(0, 3));
                if ($urandom_range(0, 199) == 0)
                    do_reset(int'($urandom_range(0, 3)));
                step($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 75, 4'($urandom));
            end
        end
        step(0, 0, 0);
        chk_en = 0;
        dut_q.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
